// File: rtl/axi4lite_master_bridge.sv
// AXI4-Lite initiator: turns single local register commands into AXI4-Lite
// read/write transactions, one outstanding at a time, and returns the
// read data / response code on a valid/ready response port. A sticky
// watchdog flag reports transactions that wait too long for B or R.
module axi4lite_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    // local command port
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_is_wr,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    // local response port
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_is_wr,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    timeout,
    // AXI4-Lite write address / data / response
    output logic [ADDR_WIDTH-1:0]   M_AWADDR,
    output logic [2:0]              M_AWPROT,
    output logic                    M_AWVALID,
    input  logic                    M_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_WSTRB,
    output logic                    M_WVALID,
    input  logic                    M_WREADY,
    input  logic [1:0]              M_BRESP,
    input  logic                    M_BVALID,
    output logic                    M_BREADY,
    // AXI4-Lite read address / data
    output logic [ADDR_WIDTH-1:0]   M_ARADDR,
    output logic [2:0]              M_ARPROT,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_RDATA,
    input  logic [1:0]              M_RRESP,
    input  logic                    M_RVALID,
    output logic                    M_RREADY
);

    localparam int STRB_W = DATA_WIDTH / 8;
    // Counter must be able to hold TIMEOUT_CYCLES itself (it saturates there).
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_B    = 3'd2,
        RD_AR   = 3'd3,
        RD_R    = 3'd4,
        RSP     = 3'd5
    } state_e;

    state_e                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
    logic [STRB_W-1:0]       wstrb_q,     wstrb_d;
    logic                    awvalid_q,   awvalid_d;
    logic                    wvalid_q,    wvalid_d;
    logic                    aw_done_q,   aw_done_d;
    logic                    w_done_q,    w_done_d;
    logic                    bready_q,    bready_d;
    logic                    arvalid_q,   arvalid_d;
    logic                    rready_q,    rready_d;
    logic                    rsp_is_wr_q, rsp_is_wr_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q,  rsp_resp_d;
    logic [CNT_W-1:0]        wd_cnt_q,    wd_cnt_d;
    logic                    timeout_q,   timeout_d;

    logic aw_fin;
    logic w_fin;

    // Next-state, AXI channel control, response capture and watchdog.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_is_wr_d = rsp_is_wr_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        wd_cnt_d    = wd_cnt_q;
        timeout_d   = timeout_q;
        // AW and W may complete in either order or together; a channel is
        // finished once its flag is set or it handshakes this cycle.
        aw_fin      = aw_done_q | (awvalid_q & M_AWREADY);
        w_fin       = w_done_q  | (wvalid_q  & M_WREADY);

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    wd_cnt_d  = '0;
                    timeout_d = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (cmd_is_wr) begin
                        state_d   = WR_AW_W;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_AW_W: begin
                if (awvalid_q && M_AWREADY) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && M_WREADY) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_fin && w_fin) begin
                    state_d  = WR_B;
                    bready_d = 1'b1;
                end
            end
            WR_B: begin
                if (bready_q && M_BVALID) begin
                    rsp_resp_d  = M_BRESP;
                    rsp_rdata_d = '0;
                    rsp_is_wr_d = 1'b1;
                    bready_d    = 1'b0;
                    state_d     = RSP;
                end
            end
            RD_AR: begin
                if (arvalid_q && M_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_R;
                end
            end
            RD_R: begin
                if (rready_q && M_RVALID) begin
                    rsp_rdata_d = M_RDATA;
                    rsp_resp_d  = M_RRESP;
                    rsp_is_wr_d = 1'b0;
                    rready_d    = 1'b0;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Watchdog only counts while waiting on the slave; it never aborts,
        // since an AXI request cannot be withdrawn once VALID is up.
        if ((state_q != IDLE) && (state_q != RSP) && (wd_cnt_q != TO_MAX)) begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
            if (wd_cnt_d == TO_MAX) timeout_d = 1'b1;
        end
    end

    // State and output registers, cleared asynchronously by ARESETN.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_is_wr_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_is_wr_q <= rsp_is_wr_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            wd_cnt_q    <= wd_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Every AXI output is a flop or a constant.
    assign M_AWADDR  = addr_q;
    assign M_AWPROT  = 3'b000;
    assign M_AWVALID = awvalid_q;
    assign M_WDATA   = wdata_q;
    assign M_WSTRB   = wstrb_q;
    assign M_WVALID  = wvalid_q;
    assign M_BREADY  = bready_q;
    assign M_ARADDR  = addr_q;
    assign M_ARPROT  = 3'b000;
    assign M_ARVALID = arvalid_q;
    assign M_RREADY  = rready_q;

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RSP);
    assign rsp_is_wr = rsp_is_wr_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_axi4lite_master_bridge.sv
module tb_axi4lite_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            ACLK;
  logic            ARESETN;
  logic            cmd_valid, cmd_ready, cmd_is_wr;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wstrb;
  logic            rsp_valid, rsp_ready, rsp_is_wr;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
  logic            timeout;
  logic [AW-1:0]   M_AWADDR, M_ARADDR;
  logic [2:0]      M_AWPROT, M_ARPROT;
  logic            M_AWVALID, M_AWREADY, M_WVALID, M_WREADY;
  logic [DW-1:0]   M_WDATA, M_RDATA;
  logic [DW/8-1:0] M_WSTRB;
  logic [1:0]      M_BRESP, M_RRESP;
  logic            M_BVALID, M_BREADY, M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

  int tests = 0;
  int fails = 0;
  int aw_hs = 0;
  int w_hs  = 0;

  axi4lite_master_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_wr(cmd_is_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_wr(rsp_is_wr),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout(timeout),
    .M_AWADDR(M_AWADDR), .M_AWPROT(M_AWPROT), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARPROT(M_ARPROT), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    if (M_AWVALID && M_AWREADY) aw_hs <= aw_hs + 1;
    if (M_WVALID && M_WREADY)   w_hs  <= w_hs + 1;
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    tests++;
    if (o !== e) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic cyc();
    @(negedge ACLK);
  endtask

  initial begin
    ARESETN = 1'b0; cmd_valid = 1'b0; cmd_is_wr = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BVALID = 1'b0; M_BRESP = 2'b00;
    M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RDATA = '0; M_RRESP = 2'b00;
    cyc(); cyc();
    ARESETN = 1'b1;
    cyc();
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_timeout",   timeout,   1'b0);
    chk("rst_awvalid",   M_AWVALID, 1'b0);
    chk("rst_wvalid",    M_WVALID,  1'b0);
    chk("rst_arvalid",   M_ARVALID, 1'b0);
    chk("rst_bready",    M_BREADY,  1'b0);
    chk("rst_rready",    M_RREADY,  1'b0);
    chk("rst_awaddr",    M_AWADDR,  32'h0);
    chk("rst_awprot",    M_AWPROT,  3'b000);
    chk("rst_arprot",    M_ARPROT,  3'b000);

    cmd_valid = 1'b1; cmd_is_wr = 1'b1; cmd_addr = 32'h4;
    cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
    M_AWREADY = 1'b1; M_WREADY = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    chk("w0_awvalid",   M_AWVALID, 1'b1);
    chk("w0_wvalid",    M_WVALID,  1'b1);
    chk("w0_awaddr",    M_AWADDR,  32'h4);
    chk("w0_wdata",     M_WDATA,   32'hDEAD_BEEF);
    chk("w0_wstrb",     M_WSTRB,   4'hF);
    chk("w0_cmd_ready", cmd_ready, 1'b0);
    chk("w0_bready_c1", M_BREADY,  1'b0);
    cyc();
    M_AWREADY = 1'b0; M_WREADY = 1'b0;
    chk("w0_awvalid_c2", M_AWVALID, 1'b0);
    chk("w0_wvalid_c2",  M_WVALID,  1'b0);
    chk("w0_bready_c2",  M_BREADY,  1'b1);
    M_BVALID = 1'b1; M_BRESP = 2'b00;
    cyc();
    M_BVALID = 1'b0;
    chk("w0_rsp_valid", rsp_valid, 1'b1);
    chk("w0_rsp_is_wr", rsp_is_wr, 1'b1);
    chk("w0_rsp_resp",  rsp_resp,  2'b00);
    chk("w0_rsp_rdata", rsp_rdata, 32'h0);
    chk("w0_bready_c3", M_BREADY,  1'b0);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("w0_idle_rsp_valid", rsp_valid, 1'b0);
    chk("w0_idle_cmd_ready", cmd_ready, 1'b1);
    chk("w0_aw_hs", aw_hs, 1);
    chk("w0_w_hs",  w_hs,  1);

    cmd_valid = 1'b1; cmd_is_wr = 1'b0; cmd_addr = 32'h10;
    cyc();
    cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFFF;
    chk("r_arvalid_c1", M_ARVALID, 1'b1);
    chk("r_araddr_c1",  M_ARADDR,  32'h10);
    chk("r_awvalid_c1", M_AWVALID, 1'b0);
    cyc();
    chk("r_arvalid_c2", M_ARVALID, 1'b1);
    chk("r_araddr_c2",  M_ARADDR,  32'h10);
    cyc();
    chk("r_arvalid_c3", M_ARVALID, 1'b1);
    chk("r_araddr_c3",  M_ARADDR,  32'h10);
    M_ARREADY = 1'b1;
    cyc();
    M_ARREADY = 1'b0;
    chk("r_arvalid_c4", M_ARVALID, 1'b0);
    chk("r_rready_c4",  M_RREADY,  1'b1);
    cyc(); cyc();
    chk("r_rready_c6",    M_RREADY,  1'b1);
    chk("r_rsp_valid_c6", rsp_valid, 1'b0);
    cyc();
    M_RVALID = 1'b1; M_RDATA = 32'h1234_5678; M_RRESP = 2'b10;
    cyc();
    M_RVALID = 1'b0; M_RDATA = '0; M_RRESP = 2'b00;
    chk("r_rsp_valid", rsp_valid, 1'b1);
    chk("r_rsp_rdata", rsp_rdata, 32'h1234_5678);
    chk("r_rsp_resp",  rsp_resp,  2'b10);
    chk("r_rsp_is_wr", rsp_is_wr, 1'b0);
    chk("r_rready_c8", M_RREADY,  1'b0);
    chk("r_timeout",   timeout,   1'b0);

    cmd_valid = 1'b1; cmd_is_wr = 1'b1; cmd_addr = 32'h20;
    cmd_wdata = 32'hA5A5_0001; cmd_wstrb = 4'h3;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h1234_5678);
      chk("bp_rsp_resp",  rsp_resp,  2'b10);
      chk("bp_cmd_ready", cmd_ready, 1'b0);
      chk("bp_awvalid",   M_AWVALID, 1'b0);
      chk("bp_arvalid",   M_ARVALID, 1'b0);
      cyc();
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("bp_idle_rsp_valid", rsp_valid, 1'b0);
    chk("bp_idle_cmd_ready", cmd_ready, 1'b1);
    chk("bp_idle_awvalid",   M_AWVALID, 1'b0);

    cyc();
    cmd_valid = 1'b0;
    chk("awf_awvalid_c1", M_AWVALID, 1'b1);
    chk("awf_wvalid_c1",  M_WVALID,  1'b1);
    chk("awf_awaddr",     M_AWADDR,  32'h20);
    chk("awf_wdata",      M_WDATA,   32'hA5A5_0001);
    chk("awf_wstrb",      M_WSTRB,   4'h3);
    M_AWREADY = 1'b1;
    cyc();
    M_AWREADY = 1'b0;
    chk("awf_awvalid_c2", M_AWVALID, 1'b0);
    chk("awf_wvalid_c2",  M_WVALID,  1'b1);
    chk("awf_bready_c2",  M_BREADY,  1'b0);
    cyc();
    chk("awf_awvalid_c3", M_AWVALID, 1'b0);
    chk("awf_wvalid_c3",  M_WVALID,  1'b1);
    chk("awf_bready_c3",  M_BREADY,  1'b0);
    chk("awf_wdata_c3",   M_WDATA,   32'hA5A5_0001);
    cyc();
    chk("awf_wvalid_c4",  M_WVALID,  1'b1);
    M_WREADY = 1'b1;
    cyc();
    M_WREADY = 1'b0;
    chk("awf_wvalid_c5",  M_WVALID,  1'b0);
    chk("awf_awvalid_c5", M_AWVALID, 1'b0);
    chk("awf_bready_c5",  M_BREADY,  1'b1);
    M_BVALID = 1'b1; M_BRESP = 2'b11;
    cyc();
    M_BVALID = 1'b0;
    chk("awf_rsp_valid", rsp_valid, 1'b1);
    chk("awf_rsp_is_wr", rsp_is_wr, 1'b1);
    chk("awf_rsp_resp",  rsp_resp,  2'b11);
    chk("awf_rsp_rdata", rsp_rdata, 32'h0);
    chk("awf_aw_hs", aw_hs, 2);
    chk("awf_w_hs",  w_hs,  2);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;

    cmd_valid = 1'b1; cmd_is_wr = 1'b1; cmd_addr = 32'h24;
    cmd_wdata = 32'h0BAD_F00D; cmd_wstrb = 4'h8;
    cyc();
    cmd_valid = 1'b0;
    chk("wf_awvalid_c1", M_AWVALID, 1'b1);
    chk("wf_wvalid_c1",  M_WVALID,  1'b1);
    chk("wf_wstrb",      M_WSTRB,   4'h8);
    M_WREADY = 1'b1;
    cyc();
    M_WREADY = 1'b0;
    chk("wf_wvalid_c2",  M_WVALID,  1'b0);
    chk("wf_awvalid_c2", M_AWVALID, 1'b1);
    chk("wf_awaddr_c2",  M_AWADDR,  32'h24);
    chk("wf_bready_c2",  M_BREADY,  1'b0);
    cyc();
    chk("wf_awvalid_c3", M_AWVALID, 1'b1);
    chk("wf_bready_c3",  M_BREADY,  1'b0);
    cyc();
    chk("wf_awvalid_c4", M_AWVALID, 1'b1);
    M_AWREADY = 1'b1;
    cyc();
    M_AWREADY = 1'b0;
    chk("wf_awvalid_c5", M_AWVALID, 1'b0);
    chk("wf_wvalid_c5",  M_WVALID,  1'b0);
    chk("wf_bready_c5",  M_BREADY,  1'b1);
    M_BVALID = 1'b1; M_BRESP = 2'b00;
    cyc();
    M_BVALID = 1'b0;
    chk("wf_rsp_valid", rsp_valid, 1'b1);
    chk("wf_rsp_resp",  rsp_resp,  2'b00);
    chk("wf_rsp_is_wr", rsp_is_wr, 1'b1);
    chk("wf_aw_hs", aw_hs, 3);
    chk("wf_w_hs",  w_hs,  3);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("wf_idle_cmd_ready", cmd_ready, 1'b1);

    cmd_valid = 1'b1; cmd_is_wr = 1'b1; cmd_addr = 32'h30;
    cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
    M_AWREADY = 1'b1; M_WREADY = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    cyc();
    M_AWREADY = 1'b0; M_WREADY = 1'b0;
    chk("wd_bready_c2",  M_BREADY, 1'b1);
    chk("wd_timeout_c2", timeout,  1'b0);
    repeat (6) cyc();
    chk("wd_timeout_c8", timeout,  1'b0);
    cyc();
    chk("wd_timeout_c9",   timeout,   1'b1);
    chk("wd_bready_c9",    M_BREADY,  1'b1);
    chk("wd_rsp_valid_c9", rsp_valid, 1'b0);
    repeat (3) cyc();
    chk("wd_timeout_c12", timeout,  1'b1);
    chk("wd_bready_c12",  M_BREADY, 1'b1);
    M_BVALID = 1'b1; M_BRESP = 2'b10;
    cyc();
    M_BVALID = 1'b0;
    chk("wd_rsp_valid",   rsp_valid, 1'b1);
    chk("wd_rsp_resp",    rsp_resp,  2'b10);
    chk("wd_timeout_rsp", timeout,   1'b1);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("wd_timeout_idle", timeout,   1'b1);
    chk("wd_cmd_ready",    cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_is_wr = 1'b0; cmd_addr = 32'h40;
    cyc();
    cmd_valid = 1'b0;
    chk("wd_timeout_clr", timeout,   1'b0);
    chk("wd_arvalid",     M_ARVALID, 1'b1);
    chk("wd_araddr",      M_ARADDR,  32'h40);

    #2 ARESETN = 1'b0;
    #1;
    chk("ar_arvalid_async", M_ARVALID, 1'b0);
    chk("ar_rready_async",  M_RREADY,  1'b0);
    chk("ar_cmd_ready_rst", cmd_ready, 1'b1);
    cyc();
    ARESETN = 1'b1;
    cyc();
    chk("ar_cmd_ready", cmd_ready, 1'b1);
    chk("ar_rsp_valid", rsp_valid, 1'b0);
    chk("ar_timeout",   timeout,   1'b0);
    chk("ar_arvalid",   M_ARVALID, 1'b0);
    chk("ar_araddr",    M_ARADDR,  32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi4lite_master_bridge.md
Name: axi4lite_master_bridge

Overview:
- AXI4-Lite initiator. Converts single register-access commands from a local requester (test sequencer, config loader, debug port) into AXI4-Lite read/write transactions toward our AXI4-Lite register slaves.
- One transaction is outstanding at a time.
- Returns read data and response code on a valid/ready response port.
- A watchdog flags transactions that stall.

Parameters:
- ADDR_WIDTH, 32, width of the command address and of AWADDR/ARADDR.
- DATA_WIDTH, 32, data width; only 32 is supported; strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, cycles from command accept to B/R handshake before the timeout flag sets; must be ≥ 2.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  bridge can accept a command.
- cmd_is_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  requester takes the response.
- rsp_is_wr  out  1  response belongs to a write.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  captured RRESP/BRESP.
- timeout  out  1  sticky watchdog flag.
- M_AWADDR, M_AWPROT, M_AWVALID, M_AWREADY, M_WDATA, M_WSTRB, M_WVALID, M_WREADY, M_BRESP, M_BVALID, M_BREADY, M_ARADDR, M_ARPROT, M_ARVALID, M_ARREADY, M_RDATA, M_RRESP, M_RVALID, M_RREADY: standard AXI4-Lite master-side directions and widths. PROT is 3 bits, RESP is 2 bits.

Behaviour:
- One clock, ACLK. Reset is asynchronous and active-low on ARESETN. All state is flops on ACLK with async clear.
- Reset values:
  - State is IDLE.
  - All M_*VALID and M_*READY outputs are 0.
  - rsp_valid=0, timeout=0.
  - Address, data, strobe and response registers are 0.
  - cmd_ready=1 once reset is released.
- M_AWPROT and M_ARPROT are constant 3'b000.
- All AXI outputs come straight from registers; no combinational path from any input to any AXI output.
- cmd_ready = (state==IDLE).
- A command is accepted on cmd_valid && cmd_ready. At accept, cmd_addr/cmd_wdata/cmd_wstrb/cmd_is_wr are captured.
- States:
  - IDLE: on accept, go to WR_AW_W (write) or RD_AR (read). The corresponding VALIDs assert in the next cycle.
  - WR_AW_W: M_AWVALID and M_WVALID both assert together.
    - Each deasserts independently in the cycle after its own handshake. Two internal flags, aw_done and w_done, track this.
    - Either order, or both in the same cycle, is legal.
    - Once both flags are set, go to WR_B with M_BREADY=1.
  - WR_B: on M_BVALID && M_BREADY, capture M_BRESP, set rsp_rdata=0 and rsp_is_wr=1, drop M_BREADY, go to RSP.
  - RD_AR: M_ARVALID=1 until handshake, then go to RD_R with M_RREADY=1.
  - RD_R: on M_RVALID && M_RREADY, capture M_RDATA and M_RRESP, set rsp_is_wr=0, go to RSP.
  - RSP: rsp_valid=1 and the response fields are held stable until rsp_ready. On handshake, go to IDLE.
- A VALID, once asserted, is never withdrawn before its handshake. Address, data and strobe are stable while VALID is high.
- Minimum latency against a zero-wait slave: command accepted at cycle 0, VALIDs high at cycle 1, RSP entered at cycle 3 for both reads and writes. The next command is accepted one cycle after the rsp handshake.
- Watchdog:
  - The counter clears at command accept and increments every cycle outside IDLE and RSP.
  - When it reaches TIMEOUT_CYCLES, timeout sets and the counter saturates.
  - The transaction is not aborted; the bridge keeps waiting, because AXI forbids withdrawing a request.
  - timeout clears at the next command accept.
- Response codes are passed through unchanged. SLVERR and DECERR are not errors of this bridge.
- Reset mid-transaction: all VALID and READY outputs drop asynchronously and the bridge returns to IDLE. The interconnect is reset from the same ARESETN.
- cmd_valid while busy is ignored (cmd_ready=0). The requester holds its command.

Test Plan:
- Write addr 0x0000_0004, data 0xDEAD_BEEF, strb 4'hF, zero-wait slave -> AW/W VALID at cycle 1 with AWADDR=0x4, WDATA=0xDEADBEEF, WSTRB=F; rsp_valid at cycle 3 with rsp_is_wr=1, rsp_resp=0, rsp_rdata=0.
- Slave gives AWREADY 3 cycles before WREADY, then repeat with WREADY first -> each VALID drops only after its own handshake; BREADY asserts only after both; no duplicate AW or W handshakes.
- Read addr 0x10; slave delays ARREADY 2 cycles and RVALID 4 cycles, returning 0x1234_5678 with RRESP=2'b10 -> rsp_rdata=0x12345678, rsp_resp=2'b10, ARADDR stable throughout.
- Response backpressure: hold rsp_ready=0 for 5 cycles -> rsp fields stable, cmd_ready=0, no new AXI activity; accept a new command one cycle after the rsp handshake.
- Watchdog with TIMEOUT_CYCLES=8, slave never asserts BVALID -> timeout=1 on the 8th waiting cycle and M_BREADY remains 1; then BVALID arrives -> normal response; the next accepted command clears timeout.
- Assert ARESETN=0 mid-read while ARVALID=1 -> ARVALID=0 immediately and asynchronously; after release cmd_ready=1, rsp_valid=0, timeout=0.
